// File: rtl/map_write_arbiter_if.sv
// Bus bundle between the map write arbiter and its requesters (loader, tank hit detectors)
// plus the tile RAM write port.
interface map_write_arbiter_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 2
);
  logic              load_start;
  logic              load_valid;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_data;
  logic              load_done;
  logic              hit1_valid;
  logic [ADDR_W-1:0] hit1_addr;
  logic              hit2_valid;
  logic [ADDR_W-1:0] hit2_addr;
  logic              hit1_ready;
  logic              hit2_ready;
  logic              load_busy;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;

  modport master (
    output load_start, load_valid, load_addr, load_data, load_done,
    output hit1_valid, hit1_addr, hit2_valid, hit2_addr,
    input  hit1_ready, hit2_ready, load_busy, ram_we, ram_addr, ram_wdata
  );

  modport slave (
    input  load_start, load_valid, load_addr, load_data, load_done,
    input  hit1_valid, hit1_addr, hit2_valid, hit2_addr,
    output hit1_ready, hit2_ready, load_busy, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/map_write_arbiter.sv
// Single-write-port arbiter for the map tile RAM: map loader vs. two tank bullet-hit slots.
// Build option MAPWR_FIXED_PRI_EN: tank 1 always wins a tie instead of round-robin.
module map_write_arbiter #(
  parameter int              ADDR_W   = 10,
  parameter int              DATA_W   = 2,
  parameter logic [DATA_W-1:0] HIT_TILE = '0
) (
  input logic                clk,
  input logic                resetN,
  map_write_arbiter_if.slave bus
);

  typedef enum logic {IDLE, LOAD} state_t;

  state_t            state_q, state_d;
  logic              pend1_q, pend1_d, pend2_q, pend2_d;
  logic [ADDR_W-1:0] addr1_q, addr1_d, addr2_q, addr2_d;
  logic              rdy1_q, rdy1_d, rdy2_q, rdy2_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              pick1;
`ifndef MAPWR_FIXED_PRI_EN
  logic              last2_q, last2_d;   // 1: tank 2 won the most recent tie
`endif

  always_comb begin
    state_d = state_q;
    pend1_d = pend1_q;
    pend2_d = pend2_q;
    addr1_d = addr1_q;
    addr2_d = addr2_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    pick1   = 1'b1;
`ifndef MAPWR_FIXED_PRI_EN
    last2_d = last2_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.load_start) begin
          // Map is being replaced: queued and same-cycle hits are discarded.
          state_d = LOAD;
          pend1_d = 1'b0;
          pend2_d = 1'b0;
        end else begin
          if (pend1_q && pend2_q && (addr1_q == addr2_q)) begin
            we_d    = 1'b1;
            waddr_d = addr1_q;
            wdata_d = HIT_TILE;
            pend1_d = 1'b0;
            pend2_d = 1'b0;
          end else if (pend1_q || pend2_q) begin
            if (pend1_q && pend2_q) begin
`ifdef MAPWR_FIXED_PRI_EN
              pick1 = 1'b1;
`else
              pick1   = last2_q;
              last2_d = !last2_q;
`endif
            end else begin
              pick1 = pend1_q;
            end
            we_d    = 1'b1;
            wdata_d = HIT_TILE;
            if (pick1) begin
              waddr_d = addr1_q;
              pend1_d = 1'b0;
            end else begin
              waddr_d = addr2_q;
              pend2_d = 1'b0;
            end
          end
          // ready implies the slot is empty, so capture never collides with service
          if (bus.hit1_valid && rdy1_q) begin
            pend1_d = 1'b1;
            addr1_d = bus.hit1_addr;
          end
          if (bus.hit2_valid && rdy2_q) begin
            pend2_d = 1'b1;
            addr2_d = bus.hit2_addr;
          end
        end
      end
      LOAD: begin
        if (bus.load_valid) begin
          we_d    = 1'b1;
          waddr_d = bus.load_addr;
          wdata_d = bus.load_data;
        end
        if (bus.load_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    rdy1_d = (state_d == IDLE) && !pend1_d;
    rdy2_d = (state_d == IDLE) && !pend2_d;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= IDLE;
      pend1_q <= 1'b0;
      pend2_q <= 1'b0;
      addr1_q <= '0;
      addr2_q <= '0;
      rdy1_q  <= 1'b1;
      rdy2_q  <= 1'b1;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
`ifndef MAPWR_FIXED_PRI_EN
      last2_q <= 1'b1;
`endif
    end else begin
      state_q <= state_d;
      pend1_q <= pend1_d;
      pend2_q <= pend2_d;
      addr1_q <= addr1_d;
      addr2_q <= addr2_d;
      rdy1_q  <= rdy1_d;
      rdy2_q  <= rdy2_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
`ifndef MAPWR_FIXED_PRI_EN
      last2_q <= last2_d;
`endif
    end
  end

  assign bus.hit1_ready = rdy1_q;
  assign bus.hit2_ready = rdy2_q;
  assign bus.load_busy  = (state_q == LOAD);
  assign bus.ram_we     = we_q;
  assign bus.ram_addr   = waddr_q;
  assign bus.ram_wdata  = wdata_q;

endmodule

// File: tb/tb_map_write_arbiter.sv
// Self-checking bench for map_write_arbiter: directed vector table, hand-written load/reset
// sequences, and randomized traffic against a behavioural reference model.
module tb_map_write_arbiter;

  localparam int          AW  = 10;
  localparam int          DW  = 2;
  localparam logic [DW-1:0] HIT = 2'd0;
`ifdef MAPWR_FIXED_PRI_EN
  localparam logic [AW-1:0] T2A = 10'h010;
  localparam logic [AW-1:0] T2B = 10'h020;
`else
  localparam logic [AW-1:0] T2A = 10'h020;
  localparam logic [AW-1:0] T2B = 10'h010;
`endif

  logic clk = 1'b0;
  logic resetN;

  map_write_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  map_write_arbiter #(.ADDR_W(AW), .DATA_W(DW), .HIT_TILE(HIT)) dut (
    .clk    (clk),
    .resetN (resetN),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: what the arbiter should hold and show next cycle.
  bit            m_load;
  bit            m_pend [2];
  logic [AW-1:0] m_paddr[2];
  int            m_last;
  bit            e_we;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_data;
  bit            e_rdy  [2];
  bit            e_busy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_load = 1'b0;
    m_pend[0] = 1'b0; m_pend[1] = 1'b0;
    m_paddr[0] = '0;  m_paddr[1] = '0;
    m_last = 1;
    e_we = 1'b0; e_addr = '0; e_data = '0;
    e_rdy[0] = 1'b1; e_rdy[1] = 1'b1;
    e_busy = 1'b0;
  endtask

  task automatic model_step();
    bit            hv[2];
    logic [AW-1:0] ha[2];
    bit            cap[2];
    int            win;
    hv[0] = bus.hit1_valid; ha[0] = bus.hit1_addr;
    hv[1] = bus.hit2_valid; ha[1] = bus.hit2_addr;
    e_we = 1'b0;
    if (m_load) begin
      if (bus.load_valid) begin
        e_we = 1'b1; e_addr = bus.load_addr; e_data = bus.load_data;
      end
      if (bus.load_done) m_load = 1'b0;
    end else if (bus.load_start) begin
      m_load = 1'b1;
      m_pend[0] = 1'b0; m_pend[1] = 1'b0;
    end else begin
      for (int k = 0; k < 2; k++) cap[k] = hv[k] && e_rdy[k];
      win = -1;
      if (m_pend[0] && m_pend[1]) begin
        if (m_paddr[0] == m_paddr[1]) begin
          e_we = 1'b1; e_addr = m_paddr[0]; e_data = HIT;
          m_pend[0] = 1'b0; m_pend[1] = 1'b0;
        end else begin
`ifdef MAPWR_FIXED_PRI_EN
          win = 0;
`else
          win = 1 - m_last;
          m_last = win;
`endif
        end
      end else if (m_pend[0]) win = 0;
      else if (m_pend[1]) win = 1;
      if (win >= 0) begin
        e_we = 1'b1; e_addr = m_paddr[win]; e_data = HIT;
        m_pend[win] = 1'b0;
      end
      for (int k = 0; k < 2; k++)
        if (cap[k]) begin m_pend[k] = 1'b1; m_paddr[k] = ha[k]; end
    end
    e_busy = m_load;
    for (int k = 0; k < 2; k++) e_rdy[k] = !m_load && !m_pend[k];
  endtask

  task automatic model_check();
    chk("model_load_busy", bus.load_busy, e_busy);
    chk("model_hit1_ready", bus.hit1_ready, e_rdy[0]);
    chk("model_hit2_ready", bus.hit2_ready, e_rdy[1]);
    chk("model_ram_we", bus.ram_we, e_we);
    if (e_we) begin
      chk("model_ram_addr", bus.ram_addr, e_addr);
      chk("model_ram_wdata", bus.ram_wdata, e_data);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    model_check();
  endtask

  task automatic clear_inputs();
    bus.load_start = 1'b0; bus.load_valid = 1'b0; bus.load_addr = '0;
    bus.load_data  = '0;   bus.load_done  = 1'b0;
    bus.hit1_valid = 1'b0; bus.hit1_addr  = '0;
    bus.hit2_valid = 1'b0; bus.hit2_addr  = '0;
  endtask

  typedef struct {
    bit            h1v;
    logic [AW-1:0] h1a;
    bit            h2v;
    logic [AW-1:0] h2a;
    bit            we;
    logic [AW-1:0] addr;
    bit            r1;
    bit            r2;
  } vec_t;

  function automatic vec_t mk(bit h1v, logic [AW-1:0] h1a, bit h2v, logic [AW-1:0] h2a,
                              bit we, logic [AW-1:0] addr, bit r1, bit r2);
    vec_t v;
    v.h1v = h1v; v.h1a = h1a; v.h2v = h2v; v.h2a = h2a;
    v.we = we; v.addr = addr; v.r1 = r1; v.r2 = r2;
    return v;
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[22];
    int   bad;

    // single hit, then three ties, merge, drop-on-busy
    vt[0]  = mk(1, 10'h05A, 0, 10'h000, 0, 10'h000, 0, 1);
    vt[1]  = mk(0, 10'h000, 0, 10'h000, 1, 10'h05A, 1, 1);
    vt[2]  = mk(0, 10'h000, 0, 10'h000, 0, 10'h000, 1, 1);
    vt[3]  = mk(1, 10'h010, 1, 10'h020, 0, 10'h000, 0, 0);
    vt[4]  = mk(0, 10'h000, 0, 10'h000, 1, 10'h010, 1, 0);
    vt[5]  = mk(0, 10'h000, 0, 10'h000, 1, 10'h020, 1, 1);
    vt[6]  = mk(0, 10'h000, 0, 10'h000, 0, 10'h000, 1, 1);
    vt[7]  = mk(1, 10'h010, 1, 10'h020, 0, 10'h000, 0, 0);
    vt[8]  = mk(0, 10'h000, 0, 10'h000, 1, T2A, T2A == 10'h010, T2A == 10'h020);
    vt[9]  = mk(0, 10'h000, 0, 10'h000, 1, T2B, 1, 1);
    vt[10] = mk(0, 10'h000, 0, 10'h000, 0, 10'h000, 1, 1);
    vt[11] = mk(1, 10'h010, 1, 10'h020, 0, 10'h000, 0, 0);
    vt[12] = mk(0, 10'h000, 0, 10'h000, 1, 10'h010, 1, 0);
    vt[13] = mk(0, 10'h000, 0, 10'h000, 1, 10'h020, 1, 1);
    vt[14] = mk(0, 10'h000, 0, 10'h000, 0, 10'h000, 1, 1);
    vt[15] = mk(1, 10'h100, 1, 10'h100, 0, 10'h000, 0, 0);
    vt[16] = mk(0, 10'h000, 0, 10'h000, 1, 10'h100, 1, 1);
    vt[17] = mk(0, 10'h000, 0, 10'h000, 0, 10'h000, 1, 1);
    vt[18] = mk(1, 10'h040, 0, 10'h000, 0, 10'h000, 0, 1);
    vt[19] = mk(1, 10'h041, 0, 10'h000, 1, 10'h040, 1, 1);
    vt[20] = mk(0, 10'h000, 0, 10'h000, 0, 10'h000, 1, 1);
    vt[21] = mk(0, 10'h000, 0, 10'h000, 0, 10'h000, 1, 1);

    // ---------------- reset values ----------------
    clear_inputs();
    resetN = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("reset_ram_we", bus.ram_we, 1'b0);
    chk("reset_ram_addr", bus.ram_addr, 10'h000);
    chk("reset_ram_wdata", bus.ram_wdata, 2'd0);
    chk("reset_hit1_ready", bus.hit1_ready, 1'b1);
    chk("reset_hit2_ready", bus.hit2_ready, 1'b1);
    chk("reset_load_busy", bus.load_busy, 1'b0);
    resetN = 1'b1;
    tick();

    // ---------------- directed vector table ----------------
    foreach (vt[i]) begin
      bus.hit1_valid = vt[i].h1v; bus.hit1_addr = vt[i].h1a;
      bus.hit2_valid = vt[i].h2v; bus.hit2_addr = vt[i].h2a;
      tick();
      chk($sformatf("vec%0d_ram_we", i), bus.ram_we, vt[i].we);
      if (vt[i].we) begin
        chk($sformatf("vec%0d_ram_addr", i), bus.ram_addr, vt[i].addr);
        chk($sformatf("vec%0d_ram_wdata", i), bus.ram_wdata, HIT);
      end
      chk($sformatf("vec%0d_hit1_ready", i), bus.hit1_ready, vt[i].r1);
      chk($sformatf("vec%0d_hit2_ready", i), bus.hit2_ready, vt[i].r2);
    end
    clear_inputs();

    // ---------------- load preempts a pending hit ----------------
    bus.hit2_valid = 1'b1; bus.hit2_addr = 10'h033;
    tick();
    clear_inputs();
    bus.load_start = 1'b1;
    tick();
    chk("preempt_ram_we", bus.ram_we, 1'b0);
    chk("preempt_load_busy", bus.load_busy, 1'b1);
    chk("preempt_hit2_ready", bus.hit2_ready, 1'b0);
    bus.load_start = 1'b0;
    bad = 0;
    for (int i = 0; i < 768; i++) begin
      logic [AW-1:0] a;
      a = AW'(i);
      bus.load_valid = 1'b1; bus.load_addr = a; bus.load_data = a[1:0];
      bus.load_done  = (i == 767);
      bus.hit1_valid = 1'b1; bus.hit1_addr = 10'h3FF;
      bus.load_start = (i == 100);
      tick();
      if (bus.ram_we !== 1'b1 || bus.ram_addr !== a || bus.ram_wdata !== a[1:0]) bad++;
      if (i < 767 && bus.load_busy !== 1'b1) bad++;
    end
    chk("load_stream_errors", bad, 0);
    chk("load_busy_after_done", bus.load_busy, 1'b0);
    clear_inputs();
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.ram_we !== 1'b0) bad++;
    end
    chk("post_load_no_write", bad, 0);

    // ---------------- load_start concurrent with a hit ----------------
    bus.hit1_valid = 1'b1; bus.hit1_addr = 10'h077; bus.load_start = 1'b1;
    tick();
    clear_inputs();
    bus.load_valid = 1'b1; bus.load_addr = 10'h005; bus.load_data = 2'd3; bus.load_done = 1'b1;
    tick();
    clear_inputs();
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.ram_we === 1'b1 && bus.ram_addr === 10'h077) bad++;
    end
    chk("start_beats_hit", bad, 0);

    // ---------------- async reset mid-load ----------------
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
    for (int i = 0; i < 300; i++) begin
      bus.load_valid = 1'b1; bus.load_addr = AW'(i); bus.load_data = 2'(i);
      tick();
    end
    #2;
    resetN = 1'b0;
    clear_inputs();
    #1;
    chk("midload_reset_ram_we", bus.ram_we, 1'b0);
    chk("midload_reset_load_busy", bus.load_busy, 1'b0);
    chk("midload_reset_ram_addr", bus.ram_addr, 10'h000);
    chk("midload_reset_hit1_ready", bus.hit1_ready, 1'b1);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    resetN = 1'b1;
    bus.hit1_valid = 1'b1; bus.hit1_addr = 10'h001;
    tick();
    clear_inputs();
    tick();
    chk("after_reset_hit_we", bus.ram_we, 1'b1);
    chk("after_reset_hit_addr", bus.ram_addr, 10'h001);

    // ---------------- randomized traffic vs. model ----------------
    for (int c = 0; c < 2000; c++) begin
      bus.hit1_valid = ($urandom_range(0, 9) < 4);
      bus.hit1_addr  = 10'h200 + AW'($urandom_range(0, 5));
      bus.hit2_valid = ($urandom_range(0, 9) < 4);
      bus.hit2_addr  = 10'h200 + AW'($urandom_range(0, 5));
      bus.load_valid = ($urandom_range(0, 1) == 1);
      bus.load_addr  = AW'($urandom_range(0, 767));
      bus.load_data  = DW'($urandom_range(0, 3));
      if (m_load) begin
        bus.load_start = ($urandom_range(0, 9) == 0);
        bus.load_done  = ($urandom_range(0, 19) == 0);
      end else begin
        bus.load_start = ($urandom_range(0, 59) == 0);
        bus.load_done  = ($urandom_range(0, 7) == 0);
      end
      tick();
    end
    clear_inputs();
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/map_write_arbiter.md
Name: map_write_arbiter

Overview:
- Single-write-port arbiter for the map tile RAM.
- Sharers: the map loader (bulk load on random pick or map change) and the bullet-hit detectors of tank 1 and tank 2 (brick destruction).
- Buffers one pending hit per tank, round-robins between tanks, gives the loader exclusive ownership during a load.
- Issues at most one registered RAM write per clock.

Parameters:
- ADDR_W, 10, tile address width (32x24 map = 768 cells).
- DATA_W, 2, tile code width.
- HIT_TILE, 0, tile code written on a bullet hit (empty tile).

Ports:
- clk  in  1  system clock.
- resetN  in  1  asynchronous active-low reset.
- load_start  in  1  one-cycle pulse; begin map load (from game controller randomPick/pickMap).
- load_valid  in  1  loader write strobe, honoured only in LOAD.
- load_addr  in  ADDR_W  loader tile address.
- load_data  in  DATA_W  loader tile code.
- load_done  in  1  one-cycle pulse; last loader write is on this cycle or earlier.
- hit1_valid  in  1  tank 1 bullet hit a destructible tile.
- hit1_addr  in  ADDR_W  tile address of tank 1 hit.
- hit2_valid  in  1  tank 2 bullet hit a destructible tile.
- hit2_addr  in  ADDR_W  tile address of tank 2 hit.
- hit1_ready  out  1  tank 1 pending slot free, registered.
- hit2_ready  out  1  tank 2 pending slot free, registered.
- load_busy  out  1  high while in LOAD state.
- ram_we  out  1  RAM write enable, registered.
- ram_addr  out  ADDR_W  RAM write address, registered.
- ram_wdata  out  DATA_W  RAM write data, registered.

Behaviour:
- Reset values:
  - state IDLE; pend1 = pend2 = 0.
  - last_grant = tank 2, so tank 1 wins the first tie.
  - ram_we = 0, ram_addr = 0, ram_wdata = 0.
  - hit1_ready = hit2_ready = 1, load_busy = 0.
- States: IDLE (serve hits), LOAD (loader owns RAM).
- IDLE -> LOAD on load_start. LOAD -> IDLE on the cycle after load_done. load_start while in LOAD is ignored.
- Entering LOAD:
  - pend1 and pend2 are cleared; the map is being replaced, so queued hits are discarded.
  - hitN_valid is ignored for the whole of LOAD; hitN_ready = 0 throughout LOAD.
- LOAD:
  - each load_valid cycle produces ram_we = 1 next cycle with load_addr/load_data; no hit writes occur.
  - load_valid and load_done in the same cycle: that write is still performed.
- Hit capture in IDLE: hitN_valid && hitN_ready sets pendN and stores the address. hitN_valid while !hitN_ready is dropped silently.
- Service in IDLE: one pending slot is served per cycle; ram_we = 1 next cycle with the stored address and HIT_TILE, and pendN clears.
  - Only one pending: serve it.
  - Both pending: serve the tank that is not last_grant; update last_grant.
  - Both pending with equal addresses: one write is issued, both slots clear, last_grant is unchanged.
- Ready timing:
  - ready is registered: = !pendN after the update, forced 0 in LOAD.
  - A slot served in cycle t is ready again in cycle t+1.
  - A new hit captured in cycle t+1 is written at the earliest in cycle t+3.
- Latency: capture to ram_we = 2 cycles when uncontended.
- load_start in the same cycle as a hit capture: LOAD wins, and the hit is discarded.
- Reset mid-load: immediate return to IDLE with all outputs at reset values. The loader is restarted by the game controller.
- ram_we is deasserted on every cycle with no write.

Optional Feature:
- Macro MAPWR_FIXED_PRI_EN.
- Defined: tank 1 always wins a tie; last_grant is unused (may be removed).
- Undefined (default): round-robin as above.
- Same-address merge behaviour is identical in both builds.

Test Plan:
- Reset then single hit: hit1_valid=1, hit1_addr=0x05A for one cycle -> ram_we=1, ram_addr=0x05A, ram_wdata=0 exactly 2 cycles later; hit1_ready low for 1 cycle only.
- Tie round-robin: hit1 (0x010) and hit2 (0x020) same cycle, repeated 3 times after each drain -> write order 0x010,0x020 / 0x020,0x010 / 0x010,0x020.
  - With MAPWR_FIXED_PRI_EN: 0x010 first every time.
- Merge: hit1_addr = hit2_addr = 0x100 same cycle -> exactly one ram_we pulse at 0x100; both readys high 2 cycles after capture.
- Load preempts: pend2 set (0x033), then load_start -> no write to 0x033.
  - load_busy=1; 768 load_valid writes (addr 0..767, data = addr[1:0]) appear 1 cycle delayed, in order.
  - hit1_valid during LOAD produces no write; load_busy drops 1 cycle after load_done.
- Drop on busy: hit1 at 0x040 then hit1 at 0x041 on the next cycle (ready low) -> only 0x040 written.
- Async reset mid-LOAD: assert resetN=0 at write 300 -> ram_we=0, load_busy=0 immediately; after release, hit at 0x001 is written normally.
